// File: rtl/id_fetch_recv.sv
// id_fetch_recv: decode-side receiver of the fetch-to-decode interface.
// Latches {pc,inst} beats under a valid/ready handshake and resolves b/bl/jirl/beq/bne
// in decode. The redirect goes back to fetch on br_bus. The wrong-path beat accepted
// alongside a taken branch is cancelled.
// Optional feature: define ID_BR_CMP_EXT_EN to also resolve blt/bge/bltu/bgeu.
// Without the macro those four opcodes are passed to execute as ordinary instructions.
module id_fetch_recv #(
  parameter bit DROP_FIRST = 1'b1  // discard the first beat accepted after reset release
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_Valid,
  input  logic [63:0] IF_to_ID_Bus,
  output logic        ID_Unit_Ready,
  output logic [32:0] br_bus,
  input  logic        EX_Allowin,
  output logic        ID_to_EX_Valid,
  output logic [63:0] ID_to_EX_Bus,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2
);

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
`ifdef ID_BR_CMP_EXT_EN
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;
`endif

  logic        id_valid;
  logic        skip_first;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        accept;
  logic        is_taken;
  logic        br_taken;
  logic [31:0] target;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [5:0]  op;
  logic [15:0] offs16;
  logic [25:0] offs26;
  logic [31:0] offs16_ext;
  logic [31:0] offs26_ext;

  // Decode never stalls on its own (ready_go is constant 1), so readiness only
  // depends on whether the held instruction can leave this cycle.
  assign ID_Unit_Ready  = ~id_valid | EX_Allowin;
  assign accept         = ID_Unit_Ready & IF_Valid;
  assign ID_to_EX_Valid = id_valid;
  assign ID_to_EX_Bus   = {id_pc, id_inst};
  assign rf_raddr1      = id_inst[9:5];
  assign rf_raddr2      = id_inst[4:0];

  assign op         = id_inst[31:26];
  assign offs16     = id_inst[25:10];
  assign offs26     = {id_inst[9:0], id_inst[25:10]};
  assign offs16_ext = {{14{offs16[15]}}, offs16, 2'b00};
  assign offs26_ext = {{4{offs26[25]}}, offs26, 2'b00};
  assign seq_pc     = id_pc + 32'd4;

  // Branch resolution: decide taken and compute the redirect target of the held instruction.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    is_taken = 1'b0;
    target   = id_pc + offs16_ext;
    case (op)
      OP_B, OP_BL: begin
        is_taken = 1'b1;
        target   = id_pc + offs26_ext;
      end
      OP_JIRL: begin
        is_taken = 1'b1;
        target   = rf_rdata1 + offs16_ext;
      end
      OP_BEQ:  is_taken = (rf_rdata1 == rf_rdata2);
      OP_BNE:  is_taken = (rf_rdata1 != rf_rdata2);
`ifdef ID_BR_CMP_EXT_EN
      OP_BLT:  is_taken = ($signed(rf_rdata1) <  $signed(rf_rdata2));
      OP_BGE:  is_taken = ($signed(rf_rdata1) >= $signed(rf_rdata2));
      OP_BLTU: is_taken = (rf_rdata1 <  rf_rdata2);
      OP_BGEU: is_taken = (rf_rdata1 >= rf_rdata2);
`endif
      default: ;
    endcase
  end

  // The redirect fires only on the handoff cycle. With no live instruction the whole bus
  // reads zero, and because id_valid clears asynchronously a reset kills any redirect at once.
  assign br_taken  = id_valid & is_taken & EX_Allowin;
  assign br_target = id_valid ? (br_taken ? target : seq_pc) : 32'd0;
  assign br_bus    = {br_taken, br_target};

  // Pipeline register: load on accept. Cancel the first beat after reset and the
  // wrong-path beat fetched in the same cycle a branch redirects. Hold while execute stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      id_valid   <= 1'b0;
      skip_first <= DROP_FIRST;
      id_pc      <= 32'd0;
      id_inst    <= 32'd0;
    end else if (ID_Unit_Ready) begin
      if (accept) begin
        id_pc      <= IF_to_ID_Bus[63:32];
        id_inst    <= IF_to_ID_Bus[31:0];
        id_valid   <= ~(skip_first | br_taken);
        skip_first <= 1'b0;
      end else begin
        id_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_fetch_recv.sv
// tb_id_fetch_recv: self-checking bench for id_fetch_recv.
// A behavioural model tracks which instruction decode holds and evaluates branches with
// plain integer arithmetic. It is checked against the DUT on every cycle. Directed
// scenarios carry literal expectations, and a long randomized run follows them.
// Build with ID_BR_CMP_EXT_EN defined to exercise the extended compare branches.
module tb_id_fetch_recv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        IF_Valid;
  logic [63:0] IF_to_ID_Bus;
  logic        ID_Unit_Ready;
  logic [32:0] br_bus;
  logic        EX_Allowin;
  logic        ID_to_EX_Valid;
  logic [63:0] ID_to_EX_Bus;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;

  logic [31:0] regs [32];

  int total = 0;
  int bad   = 0;

  // model state: what decode holds, whether it is live, whether the next beat is discarded
  bit          m_valid;
  bit          m_skip;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          e_ready;
  bit          e_taken;

`ifdef ID_BR_CMP_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  id_fetch_recv dut (
    .clk            (clk),
    .resetn         (resetn),
    .IF_Valid       (IF_Valid),
    .IF_to_ID_Bus   (IF_to_ID_Bus),
    .ID_Unit_Ready  (ID_Unit_Ready),
    .br_bus         (br_bus),
    .EX_Allowin     (EX_Allowin),
    .ID_to_EX_Valid (ID_to_EX_Valid),
    .ID_to_EX_Bus   (ID_to_EX_Bus),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2)
  );

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch rule evaluated with integer arithmetic: returns {taken, target-if-taken}.
  function automatic logic [32:0] branch_eval(input logic [31:0] pc, input logic [31:0] inst,
                                              input logic [31:0] r1, input logic [31:0] r2);
    int          s16;
    int          s26;
    int          opn;
    bit          t;
    logic [31:0] rel;
    s16 = int'(inst[25:10]);
    if (s16 >= 32768) s16 -= 65536;
    s26 = int'(inst[9:0]) * 65536 + int'(inst[25:10]);
    if (s26 >= 33554432) s26 -= 67108864;
    rel = pc + 32'(s16 * 4);
    opn = int'(inst[31:26]);
    t   = 1'b0;
    if (opn == 20 || opn == 21) return {1'b1, pc + 32'(s26 * 4)};
    if (opn == 19) return {1'b1, r1 + 32'(s16 * 4)};
    if (opn == 22) t = (r1 == r2);
    if (opn == 23) t = (r1 != r2);
    if (EXT) begin
      if (opn == 24) t = (int'(r1) <  int'(r2));
      if (opn == 25) t = (int'(r1) >= int'(r2));
      if (opn == 26) t = (r1 <  r2);
      if (opn == 27) t = (r1 >= r2);
    end
    return {t, rel};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_skip  = 1'b1;
    m_pc    = 32'd0;
    m_inst  = 32'd0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare();
    logic [32:0] be;
    logic [31:0] tgt;
    be      = branch_eval(m_pc, m_inst, regs[m_inst[9:5]], regs[m_inst[4:0]]);
    e_ready = !m_valid || EX_Allowin;
    e_taken = m_valid && be[32] && EX_Allowin;
    tgt     = !m_valid ? 32'd0 : (e_taken ? be[31:0] : m_pc + 32'd4);
    check("ready", 64'(ID_Unit_Ready), 64'(e_ready));
    check("valid", 64'(ID_to_EX_Valid), 64'(m_valid));
    check("br_bus", 64'(br_bus), 64'({e_taken, tgt}));
    check("raddr", 64'({rf_raddr1, rf_raddr2}), 64'({m_inst[9:5], m_inst[4:0]}));
    if (m_valid) check("ex_bus", ID_to_EX_Bus, {m_pc, m_inst});
  endtask

  // Model state advance on the clock edge, using the inputs stable since the negedge.
  task automatic model_update();
    if (e_ready) begin
      if (IF_Valid) begin
        m_pc    = IF_to_ID_Bus[63:32];
        m_inst  = IF_to_ID_Bus[31:0];
        m_valid = !(m_skip || e_taken);
        m_skip  = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] bus, input bit ax);
    @(negedge clk);
    IF_Valid     = v;
    IF_to_ID_Bus = bus;
    EX_Allowin   = ax;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  // Assert reset partway through a cycle, check outputs immediately, then release.
  task automatic reset_mid();
    resetn = 1'b0;
    #1;
    check("rst_valid", 64'(ID_to_EX_Valid), 64'd0);
    check("rst_br_bus", 64'(br_bus), 64'd0);
    check("rst_ready", 64'(ID_Unit_Ready), 64'd1);
    model_reset();
    IF_Valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] op;
    case ($urandom_range(0, 11))
      0:       op = 6'b010100;
      1:       op = 6'b010101;
      2:       op = 6'b010011;
      3, 4:    op = 6'b010110;
      5:       op = 6'b010111;
      6:       op = 6'b011000;
      7:       op = 6'b011001;
      8:       op = 6'b011010;
      9:       op = 6'b011011;
      default: op = 6'($urandom);
    endcase
    return {op, 26'($urandom)};
  endfunction

  function automatic logic [31:0] rand_reg();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd5;
      3:       return 32'hffffffff;
      4:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    resetn       = 1'b0;
    IF_Valid     = 1'b0;
    IF_to_ID_Bus = 64'd0;
    EX_Allowin   = 1'b1;
    model_reset();
    #1;
    check("init_valid", 64'(ID_to_EX_Valid), 64'd0);
    check("init_br_bus", 64'(br_bus), 64'd0);
    check("init_ready", 64'(ID_Unit_Ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // first beat after reset release is discarded
    drive(1'b1, {32'h1bfffffc, 32'h02800421}, 1'b1); tick();
    drive(1'b1, {32'h1c000000, 32'h02800421}, 1'b1);
    check("drop_first", 64'(ID_to_EX_Valid), 64'd0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("plain_valid", 64'(ID_to_EX_Valid), 64'd1);
    check("plain_bus", ID_to_EX_Bus, 64'h1c00000002800421);
    check("plain_br", 64'(br_bus), 64'({1'b0, 32'h1c000004}));
    tick();

    // b +16: redirect, wrong-path beat dropped, target beat live
    drive(1'b1, {32'h1c000010, 32'h50001000}, 1'b1); tick();
    drive(1'b1, {32'h1c000014, 32'h02800421}, 1'b1);
    check("b_br_bus", 64'(br_bus), 64'({1'b1, 32'h1c000020}));
    tick();
    drive(1'b1, {32'h1c000020, 32'h02800421}, 1'b1);
    check("b_wrong_path", 64'(ID_to_EX_Valid), 64'd0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("b_target_live", 64'(ID_to_EX_Valid), 64'd1);
    check("b_target_pc", 64'(ID_to_EX_Bus[63:32]), 64'h1c000020);
    tick();

    // beq r1,r2 with equal then unequal operands
    regs[1] = 32'd5; regs[2] = 32'd5;
    drive(1'b1, {32'h1c000100, 32'h58001022}, 1'b1); tick();
    drive(1'b1, {32'h1c000104, 32'h02800421}, 1'b1);
    check("beq_taken", 64'(br_bus), 64'({1'b1, 32'h1c000110}));
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("beq_drop", 64'(ID_to_EX_Valid), 64'd0);
    tick();
    regs[2] = 32'd6;
    drive(1'b1, {32'h1c000200, 32'h58001022}, 1'b1); tick();
    drive(1'b1, {32'h1c000204, 32'h02800421}, 1'b1);
    check("beq_not_taken", 64'(br_bus), 64'({1'b0, 32'h1c000204}));
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("beq_no_drop", 64'(ID_to_EX_Valid), 64'd1);
    check("beq_next_pc", 64'(ID_to_EX_Bus[63:32]), 64'h1c000204);
    tick();

    // live branch stalled by execute for three cycles
    drive(1'b1, {32'h1c000300, 32'h50001000}, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {32'h1c000304, 32'h02800421}, 1'b0);
      check("stall_ready", 64'(ID_Unit_Ready), 64'd0);
      check("stall_bus", ID_to_EX_Bus, {32'h1c000300, 32'h50001000});
      check("stall_br", 64'(br_bus[32]), 64'd0);
      tick();
    end
    drive(1'b1, {32'h1c000304, 32'h02800421}, 1'b1);
    check("stall_fire", 64'(br_bus), 64'({1'b1, 32'h1c000310}));
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("stall_drop", 64'(ID_to_EX_Valid), 64'd0);
    tick();

    // blt / bltu with -1 vs 1
    regs[1] = 32'hffffffff; regs[2] = 32'd1;
    drive(1'b1, {32'h1c000400, 32'h60001022}, 1'b1); tick();
    drive(1'b0, 64'd0, 1'b1);
    check("blt_taken", 64'(br_bus[32]), 64'(EXT));
    tick();
    drive(1'b1, {32'h1c000500, 32'h68001022}, 1'b1); tick();
    drive(1'b0, 64'd0, 1'b1);
    check("bltu_not_taken", 64'(br_bus[32]), 64'd0);
    tick();

    // reset asserted while a redirect is on the bus
    drive(1'b1, {32'h1c000600, 32'h50001000}, 1'b1); tick();
    drive(1'b1, {32'h1c000604, 32'h02800421}, 1'b1);
    check("pre_rst_br", 64'(br_bus[32]), 64'd1);
    reset_mid();
    drive(1'b1, {32'h1c000700, 32'h02800421}, 1'b1); tick();
    drive(1'b1, {32'h1c000704, 32'h02800421}, 1'b1);
    check("post_rst_drop", 64'(ID_to_EX_Valid), 64'd0);
    tick();
    drive(1'b0, 64'd0, 1'b1);
    check("post_rst_live", 64'(ID_to_EX_Valid), 64'd1);
    check("post_rst_pc", 64'(ID_to_EX_Bus[63:32]), 64'h1c000704);
    tick();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = rand_reg();
      drive($urandom_range(0, 3) != 0, {$urandom & 32'hfffffffc, rand_inst()},
            $urandom_range(0, 9) < 7);
      if (i == 1000) reset_mid();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
